// File: rtl/unidade_controle.sv
// Control unit for the simple 9-bit processor: decodes IR against the external
// step counter and produces datapath enables, register selects and Done/Clear.
module unidade_controle (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] DIN,
  input  logic [2:0] Tstep,
  input  logic       G_zero,
  output logic       Clear,
  output logic       Done,
  output logic       IRin,
  output logic [7:0] Rout,
  output logic [7:0] Rin,
  output logic       Gout,
  output logic       DINout,
  output logic       Ain,
  output logic       Gin,
  output logic [1:0] AluOp,
  output logic       Illegal
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  logic [8:0] ir;
  logic       nz_flag;
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

  assign opcode = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];

  function automatic logic [7:0] reg_sel(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic [1:0] alu_code(input logic [2:0] op);
    case (op)
      OP_SUB:  return 2'b01;
      OP_AND:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    Clear   = 1'b0;
    Done    = 1'b0;
    IRin    = 1'b0;
    Rout    = 8'h00;
    Rin     = 8'h00;
    Gout    = 1'b0;
    DINout  = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AluOp   = 2'b00;
    Illegal = 1'b0;
    if (Reset) begin
      Clear = 1'b1;
    end else begin
      case (Tstep)
        T0: begin
          if (Run) IRin  = 1'b1;
          else     Clear = 1'b1;
        end
        T1: begin
          case (opcode)
            OP_MV: begin
              Rout  = reg_sel(ry);
              Rin   = reg_sel(rx);
              Done  = 1'b1;
              Clear = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              Rin    = reg_sel(rx);
              Done   = 1'b1;
              Clear  = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              Rout = reg_sel(rx);
              Ain  = 1'b1;
            end
            OP_MVNZ: begin
              // Conditional move completes either way; only the selects depend on the flag.
              if (nz_flag) begin
                Rout = reg_sel(ry);
                Rin  = reg_sel(rx);
              end
              Done  = 1'b1;
              Clear = 1'b1;
            end
            default: begin
              Illegal = 1'b1;
              Done    = 1'b1;
              Clear   = 1'b1;
            end
          endcase
        end
        T2: begin
          if (is_alu(opcode)) begin
            Rout  = reg_sel(ry);
            Gin   = 1'b1;
            AluOp = alu_code(opcode);
          end else begin
            Clear = 1'b1;
          end
        end
        T3: begin
          if (is_alu(opcode)) begin
            Gout  = 1'b1;
            Rin   = reg_sel(rx);
            Done  = 1'b1;
            Clear = 1'b1;
          end else begin
            Clear = 1'b1;
          end
        end
        // Unassigned steps only pull the counter back to T0.
        default: Clear = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir      <= 9'd0;
      nz_flag <= 1'b0;
    end else begin
      if (IRin) ir <= DIN;
      // G holds the ALU result being written back this cycle.
      if (Tstep == T3 && is_alu(opcode)) nz_flag <= ~G_zero;
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: driver queues the expected output word
// per cycle, a negedge monitor pops and compares it against the DUT.
module tb_unidade_controle;

  logic       Clock;
  logic       Reset;
  logic       Run;
  logic [8:0] DIN;
  logic [2:0] Tstep;
  logic       G_zero;
  logic       Clear;
  logic       Done;
  logic       IRin;
  logic [7:0] Rout;
  logic [7:0] Rin;
  logic       Gout;
  logic       DINout;
  logic       Ain;
  logic       Gin;
  logic [1:0] AluOp;
  logic       Illegal;

  unidade_controle dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .DIN    (DIN),
    .Tstep  (Tstep),
    .G_zero (G_zero),
    .Clear  (Clear),
    .Done   (Done),
    .IRin   (IRin),
    .Rout   (Rout),
    .Rin    (Rin),
    .Gout   (Gout),
    .DINout (DINout),
    .Ain    (Ain),
    .Gin    (Gin),
    .AluOp  (AluOp),
    .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [25:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic        started = 1'b0;
  logic        stim_done = 1'b0;
  logic        drain_checked = 1'b0;
  int          drain_wait = 0;
  logic [25:0] act;

  assign act = {Clear, Done, IRin, Rout, Rin, Gout, DINout, Ain, Gin, AluOp, Illegal};

  // {Clear,Done,IRin,Rout,Rin,Gout,DINout,Ain,Gin,AluOp,Illegal}
  function automatic logic [25:0] mk(input logic clr, input logic dn, input logic irn,
                                     input logic [7:0] ro, input logic [7:0] ri,
                                     input logic go, input logic dio, input logic ai,
                                     input logic gi, input logic [1:0] op, input logic il);
    return {clr, dn, irn, ro, ri, go, dio, ai, gi, op, il};
  endfunction

  function automatic logic [25:0] e_clr();
    return mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  function automatic logic [25:0] e_irin();
    return mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  function automatic logic [25:0] e_fin(input logic [7:0] ro, input logic [7:0] ri,
                                        input logic go, input logic dio, input logic il);
    return mk(1'b1, 1'b1, 1'b0, ro, ri, go, dio, 1'b0, 1'b0, 2'b00, il);
  endfunction

  function automatic logic [25:0] e_mid(input logic [7:0] ro, input logic ai,
                                        input logic gi, input logic [1:0] op);
    return mk(1'b0, 1'b0, 1'b0, ro, 8'h00, 1'b0, 1'b0, ai, gi, op, 1'b0);
  endfunction

  function automatic logic onehot0(input logic [7:0] v);
    return (v & (v - 8'd1)) == 8'd0;
  endfunction

  task automatic apply(input logic rst, input logic run, input logic [8:0] din,
                       input logic gz, input logic [2:0] ts, input logic [25:0] e,
                       input string nm);
    exp_t tmp;
    @(posedge Clock);
    #1;
    Reset  = rst;
    Run    = run;
    DIN    = din;
    G_zero = gz;
    Tstep  = ts;
    tmp.exp  = e;
    tmp.name = nm;
    sb.push_back(tmp);
    started = 1'b1;
  endtask

  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
      end
    end
    if (started) begin
      checks++;
      if (!(onehot0(Rin) && onehot0(Rout) &&
            (int'(Gout) + int'(DINout) + int'(|Rout)) <= 1)) begin
        errors++;
        $display("FAIL bus_sel: got Rin=%h Rout=%h Gout=%b DINout=%b required one-hot selects and single bus driver",
                 Rin, Rout, Gout, DINout);
      end
    end
    if (stim_done && !drain_checked) begin
      drain_wait++;
      if (drain_wait == 3) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL drain: got %0d pending expectations required 0", sb.size());
        end
        drain_checked = 1'b1;
      end
    end
  end

  initial begin
    Reset = 1'b1; Run = 1'b0; DIN = 9'd0; Tstep = 3'd0; G_zero = 1'b0;

    apply(1'b1, 1'b0, 9'd0, 1'b0, 3'd0, e_clr(), "reset_t0");
    apply(1'b1, 1'b1, 9'b010001010, 1'b0, 3'd3, e_clr(), "reset_t3");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd0, e_clr(), "idle_t0");

    // mvi R3, #5
    apply(1'b0, 1'b1, 9'b001011000, 1'b0, 3'd0, e_irin(), "mvi_t0");
    apply(1'b0, 1'b0, 9'h005, 1'b0, 3'd1, e_fin(8'h00, 8'h08, 1'b0, 1'b1, 1'b0), "mvi_t1");

    // add R1,R2 with nonzero result -> nz_flag=1
    apply(1'b0, 1'b1, 9'b010001010, 1'b0, 3'd0, e_irin(), "add_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_mid(8'h02, 1'b1, 1'b0, 2'b00), "add_t1");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd2, e_mid(8'h04, 1'b0, 1'b1, 2'b00), "add_t2");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd3, e_fin(8'h00, 8'h02, 1'b1, 1'b0, 1'b0), "add_t3");
    apply(1'b0, 1'b1, 9'b101000001, 1'b0, 3'd0, e_irin(), "mvnz_a_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_fin(8'h02, 8'h01, 1'b0, 1'b0, 1'b0), "mvnz_a_t1");

    // sub R2,R3 with zero result -> nz_flag=0
    apply(1'b0, 1'b1, 9'b011010011, 1'b0, 3'd0, e_irin(), "sub_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_mid(8'h04, 1'b1, 1'b0, 2'b00), "sub_t1");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd2, e_mid(8'h08, 1'b0, 1'b1, 2'b01), "sub_t2");
    apply(1'b0, 1'b0, 9'd0, 1'b1, 3'd3, e_fin(8'h00, 8'h04, 1'b1, 1'b0, 1'b0), "sub_t3");
    apply(1'b0, 1'b1, 9'b101000001, 1'b0, 3'd0, e_irin(), "mvnz_b_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_fin(8'h00, 8'h00, 1'b0, 1'b0, 1'b0), "mvnz_b_t1");
    apply(1'b0, 1'b1, 9'b101000001, 1'b0, 3'd0, e_irin(), "mvnz_c_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_fin(8'h00, 8'h00, 1'b0, 1'b0, 1'b0), "mvnz_c_t1");

    // and R4,R5 with nonzero result
    apply(1'b0, 1'b1, 9'b100100101, 1'b0, 3'd0, e_irin(), "and_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_mid(8'h10, 1'b1, 1'b0, 2'b00), "and_t1");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd2, e_mid(8'h20, 1'b0, 1'b1, 2'b10), "and_t2");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd3, e_fin(8'h00, 8'h10, 1'b1, 1'b0, 1'b0), "and_t3");
    apply(1'b0, 1'b1, 9'b101000001, 1'b0, 3'd0, e_irin(), "mvnz_d_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_fin(8'h02, 8'h01, 1'b0, 1'b0, 1'b0), "mvnz_d_t1");

    // illegal opcode and recovery steps
    apply(1'b0, 1'b1, 9'b111000000, 1'b0, 3'd0, e_irin(), "ill_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_fin(8'h00, 8'h00, 1'b0, 1'b0, 1'b1), "ill_t1");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd5, e_clr(), "ill_t5");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd2, e_clr(), "ill_t2");

    // reset in the middle of an add
    apply(1'b0, 1'b1, 9'b010001010, 1'b0, 3'd0, e_irin(), "abort_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_mid(8'h02, 1'b1, 1'b0, 2'b00), "abort_t1");
    apply(1'b1, 1'b0, 9'd0, 1'b0, 3'd2, e_clr(), "abort_rst_t2");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd0, e_clr(), "post_rst_idle0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd0, e_clr(), "post_rst_idle1");
    // IR cleared to mv R0,R0
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_fin(8'h01, 8'h01, 1'b0, 1'b0, 1'b0), "ir_cleared");
    // nz_flag cleared by reset
    apply(1'b0, 1'b1, 9'b101000001, 1'b0, 3'd0, e_irin(), "mvnz_e_t0");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd1, e_fin(8'h00, 8'h00, 1'b0, 1'b0, 1'b0), "mvnz_e_t1");

    // back-to-back with Run held high
    apply(1'b0, 1'b1, 9'b000011110, 1'b0, 3'd0, e_irin(), "b2b_mv_t0");
    apply(1'b0, 1'b1, 9'd0, 1'b0, 3'd1, e_fin(8'h40, 8'h08, 1'b0, 1'b0, 1'b0), "b2b_mv_t1");
    apply(1'b0, 1'b1, 9'b010111000, 1'b0, 3'd0, e_irin(), "b2b_add_t0");
    apply(1'b0, 1'b1, 9'd0, 1'b0, 3'd1, e_mid(8'h80, 1'b1, 1'b0, 2'b00), "b2b_add_t1");
    apply(1'b0, 1'b1, 9'd0, 1'b0, 3'd2, e_mid(8'h01, 1'b0, 1'b1, 2'b00), "b2b_add_t2");
    apply(1'b0, 1'b1, 9'd0, 1'b1, 3'd3, e_fin(8'h00, 8'h80, 1'b1, 1'b0, 1'b0), "b2b_add_t3");
    apply(1'b0, 1'b1, 9'b000001010, 1'b0, 3'd0, e_irin(), "b2b_mv2_t0");
    apply(1'b0, 1'b1, 9'd0, 1'b0, 3'd1, e_fin(8'h04, 8'h02, 1'b0, 1'b0, 1'b0), "b2b_mv2_t1");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd2, e_clr(), "mv_t2_recover");
    apply(1'b0, 1'b0, 9'd0, 1'b0, 3'd0, e_clr(), "final_idle");

    stim_done = 1'b1;
    for (int i = 0; i < 20 && !drain_checked; i++) @(posedge Clock);
    if (!drain_checked) begin
      $display("FAIL monitor_timeout: got no drain check required one within 20 cycles");
      $fatal(1, "monitor did not complete");
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The module SHALL have these ports: Clock (input, 1 bit, clock) and Reset (input, 1 bit, synchronous, active-high).
REQ-002 Run  input  1  start request; sampled only at Tstep=0.
REQ-003 DIN  input  9  instruction word {III,XXX,YYY} and immediate data bus.
REQ-004 Tstep  input  3  current step from the step counter.
REQ-005 G_zero  input  1  high when the datapath G register equals zero.
REQ-006 Clear  output  1  drives the step counter back to T0 on the next edge.
REQ-007 Done  output  1  one-cycle pulse on the final step of each instruction.
REQ-008 IRin  output  1  marks the cycle in which IR is loaded from DIN.
REQ-009 Rout, Rin  output  8 each  one-hot register read/write selects for R0..R7.
REQ-010 Gout, DINout  output  1 each  drive the bus from G or from DIN.
REQ-011 Ain, Gin  output  1 each  load the A register or the G register.
REQ-012 AluOp  output  2  ALU operation: 00 add, 01 sub, 10 and.
REQ-013 Illegal  output  1  one-cycle pulse on completion of an undefined opcode.

Function
REQ-014 Internal state SHALL be IR[8:0] and nz_flag (1 bit); all outputs SHALL be combinational from Tstep, IR, nz_flag, Run and Reset.
REQ-015 Outputs not asserted in a given step SHALL be 0.
REQ-016 T0 with Run=1: IRin=1 and IR<=DIN at the edge; Clear=0.
REQ-017 T0 with Run=0: Clear=1 (counter holds T0), IR unchanged, no other output asserted.
REQ-018 Opcodes IR[8:6]: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 mvnz, 110/111 illegal.
REQ-019 mv, T1: Rout[Y]=1, Rin[X]=1, Done=1, Clear=1.
REQ-020 mvi, T1: DINout=1, Rin[X]=1, Done=1, Clear=1.
REQ-021 add/sub/and, T1: Rout[X]=1, Ain=1.
REQ-022 add/sub/and, T2: Rout[Y]=1, Gin=1, AluOp per opcode.
REQ-023 add/sub/and, T3: Gout=1, Rin[X]=1, Done=1, Clear=1; at this edge nz_flag<=~G_zero.
REQ-024 mvnz, T1: if nz_flag=1 then Rout[Y]=1 and Rin[X]=1, else no register select; Done=1 and Clear=1 in both cases.
REQ-025 mvnz SHALL NOT modify nz_flag; only the T3 step of add/sub/and updates it.
REQ-026 Illegal opcode, T1: Done=1, Clear=1, Illegal=1; no Rin, Rout, Ain, Gin or bus drive.
REQ-027 Any Tstep value not assigned a step for the current opcode (e.g. T2 for mv, or 4..7) SHALL assert only Clear=1 (recovery); Done=0.
REQ-028 Rin and Rout SHALL each be one-hot or all-zero in every cycle; Gout, DINout and Rout SHALL never drive the bus together.
REQ-029 Latency: mv, mvi, mvnz and illegal take 2 cycles (T0..T1); add, sub and and take 4 cycles (T0..T3).
REQ-030 Run=1 at a T0 that directly follows Done SHALL start the next instruction with no idle cycle.
REQ-031 Run is ignored outside T0; deasserting it mid-instruction does not abort.

Reset
REQ-032 Reset=1 SHALL force IR<=0 and nz_flag<=0 at the edge.
REQ-033 During Reset=1 all outputs SHALL be 0 except Clear=1, regardless of Tstep.
REQ-034 Reset asserted mid-instruction SHALL abort it with no Rin and no Done in that cycle; after release the block SHALL wait at T0 for Run.

Verification
REQ-035 Reset, then Run=1 with DIN=001_011_000 at T0, then DIN=0x05 at T1 -> IRin at T0; at T1 DINout=1, Rin=0000_1000, Done=1, Clear=1.
REQ-036 add R1,R2 (DIN=010_001_010), G_zero=0 at T3 -> T1 Rout=0000_0010, Ain=1; T2 Rout=0000_0100, Gin=1, AluOp=00; T3 Gout=1, Rin=0000_0010, Done=1; nz_flag=1 afterwards.
REQ-037 sub with G_zero=1 at T3, then mvnz R0,R1 -> at the mvnz T1, Rin=0 and Rout=0, Done=1; repeat after an and with G_zero=0 -> Rin=0000_0001, Rout=0000_0010.
REQ-038 DIN=111_000_000 -> at T1 Illegal=1, Done=1, Clear=1, Rin=0; Tstep forced to 5 externally -> only Clear=1.
REQ-039 Reset pulsed at T2 of an add -> in that cycle Clear=1, Gin=0 and Done=0; with Run=0 after release, Clear stays 1 and Tstep stays 0.
REQ-040 Back-to-back mv then add with Run held at 1 -> the next IRin follows each Done by exactly one cycle; across all cycles Rin and Rout are one-hot or zero.
